// File: rtl/mem_fill_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_fill_arbiter_pkg                                                     |
// | Shared state/owner encodings for the I/D-cache main-memory arbiter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_fill_arbiter_pkg;

  localparam int WORDS_PER_BLK_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_FILL  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_fill_arbiter_fill_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fill_counter                                                             |
// | Issue/return word counters for one block fill, with terminal flags.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fill_counter #(
  parameter int WORDS_PER_BLK = 8,
  parameter int IDX_W         = $clog2(WORDS_PER_BLK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             issue_en_i,
  input  logic             ret_en_i,
  output logic [IDX_W-1:0] ic_o,
  output logic [IDX_W-1:0] rc_o,
  output logic             all_issued_o,
  output logic             last_ret_o
);

  // Issue counter carries one extra bit so it can hold WORDS_PER_BLK itself.
  localparam int              CNT_W      = IDX_W + 1;
  localparam logic [CNT_W-1:0] C_ISSUE_MAX = CNT_W'(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0] C_LAST_RET  = IDX_W'(WORDS_PER_BLK - 1);

  logic [CNT_W-1:0] ic_q, ic_d;
  logic [IDX_W-1:0] rc_q, rc_d;
  logic             w_all_issued;

  assign w_all_issued = (ic_q == C_ISSUE_MAX);

  always_comb begin
    ic_d = ic_q;
    rc_d = rc_q;
    if (clr_i) begin
      ic_d = '0;
      rc_d = '0;
    end else begin
      if (issue_en_i && !w_all_issued) begin
        ic_d = ic_q + CNT_W'(1);
      end
      if (ret_en_i) begin
        rc_d = rc_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_q <= '0;
      rc_q <= '0;
    end else begin
      ic_q <= ic_d;
      rc_q <= rc_d;
    end
  end

  assign ic_o         = ic_q[IDX_W-1:0];
  assign rc_o         = rc_q;
  assign all_issued_o = w_all_issued;
  assign last_ret_o   = (rc_q == C_LAST_RET);

endmodule
`default_nettype wire

// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_fill_arbiter                                                         |
// | Shares one main-memory port between D-cache stores/fills and I fills.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int   WORDS_PER_BLK = WORDS_PER_BLK_DEF,
  parameter int   ADDR_W        = 16,
  parameter int   DATA_W        = 16,
  localparam int  IDX_W         = $clog2(WORDS_PER_BLK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              busy
);

  // A block spans 2*WORDS_PER_BLK bytes; clearing the low bits gives its base.
  localparam logic [ADDR_W-1:0] C_BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLK - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [IDX_W-1:0]  w_ic;
  logic [IDX_W-1:0]  w_rc;
  logic              w_all_issued;
  logic              w_last_ret;
  logic              w_in_fill;
  logic              w_issue;
  logic              w_ret;
  logic              w_clr;
  logic [ADDR_W-1:0] w_offset;

  assign w_in_fill = (state_q == ARB_FILL);
  assign w_issue   = w_in_fill && !w_all_issued;
  assign w_ret     = w_in_fill && mem_valid;
  assign w_clr     = (state_q == ARB_DONE);
  assign w_offset  = ADDR_W'({w_ic, 1'b0});

  fill_counter #(
    .WORDS_PER_BLK (WORDS_PER_BLK),
    .IDX_W         (IDX_W)
  ) u_fill_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (w_clr),
    .issue_en_i   (w_issue),
    .ret_en_i     (w_ret),
    .ic_o         (w_ic),
    .rc_o         (w_rc),
    .all_issued_o (w_all_issued),
    .last_ret_o   (w_last_ret)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (d_wr) begin
          state_d = ARB_WRITE;
          owner_d = OWN_D;
          base_d  = d_addr & C_BLK_MASK;
        end else if (d_miss) begin
          state_d = ARB_FILL;
          owner_d = OWN_D;
          base_d  = d_addr & C_BLK_MASK;
        end else if (i_miss) begin
          state_d = ARB_FILL;
          owner_d = OWN_I;
          base_d  = i_addr & C_BLK_MASK;
        end
      end

      // Store data/address come live from the D-cache, which holds them until done.
      ARB_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_wr_done = 1'b1;
        state_d   = ARB_IDLE;
      end

      ARB_FILL: begin
        if (w_issue) begin
          mem_en   = 1'b1;
          mem_addr = base_q + w_offset;
        end
        fill_data = mem_rdata;
        i_fill_we = mem_valid && (owner_q == OWN_I);
        d_fill_we = mem_valid && (owner_q == OWN_D);
        if (mem_valid && w_last_ret) begin
          state_d = ARB_DONE;
        end
      end

      ARB_DONE: begin
        i_fill_done = (owner_q == OWN_I);
        d_fill_done = (owner_q == OWN_D);
        state_d     = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign fill_idx = w_rc;
  assign busy     = (state_q != ARB_IDLE);

endmodule
`default_nettype wire
